// File: rtl/program_loader.sv
// Boot loader: streams program words into main memory at addresses 0..Count-1,
// holding the processor in reset until the last word has been written.
module program_loader #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH:0]   Count,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic                  MemWrEn,
  output logic                  ProcReset,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  // Handshake: a word is taken on any cycle where InValid and InReady are both
  // high; InReady is a registered state decode, so the upstream never sees a
  // combinational dependency on its own InValid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic                  in_ready_q, in_ready_d;
  logic                  proc_reset_q, proc_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  xfer;
  logic                  last_word;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_wr_en_d = 1'b0;
    xfer        = in_ready_q && InValid;
    last_word   = (ptr_q == (count_q - ONE_W));

    case (state_q)
      S_IDLE, S_RUN: begin
        if (Start) begin
          if (Count > DEPTH_W) begin
            state_d = S_ERROR;
          end else if (Count == '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_LOAD;
            count_d = Count;
            ptr_d   = '0;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          mem_wr_en_d = 1'b1;
          mem_addr_d  = ptr_q[ADDR_WIDTH-1:0];
          mem_data_d  = InData;
          ptr_d       = ptr_q + ONE_W;
          if (last_word) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_RUN;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered copies of the next-state decode.
    in_ready_d   = (state_d == S_LOAD);
    busy_d       = (state_d == S_LOAD) || (state_d == S_DRAIN);
    done_d       = (state_d == S_RUN);
    error_d      = (state_d == S_ERROR);
    proc_reset_d = (state_d != S_RUN);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      count_q      <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wr_en_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      proc_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_wr_en_q  <= mem_wr_en_d;
      in_ready_q   <= in_ready_d;
      proc_reset_q <= proc_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign InReady   = in_ready_q;
  assign MemAddr   = mem_addr_q;
  assign MemData   = mem_data_q;
  assign MemWrEn   = mem_wr_en_q;
  assign ProcReset = proc_reset_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and randomized load sessions checked each
// cycle against a behavioural model of the loader plus a write scoreboard.
module tb_program_loader;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [5:0]  Count;
  logic [19:0] InData;
  logic        InValid;
  logic        InReady;
  logic [4:0]  MemAddr;
  logic [19:0] MemData;
  logic        MemWrEn;
  logic        ProcReset;
  logic        Busy;
  logic        Done;
  logic        Error;

  program_loader #(.DATA_WIDTH(20), .ADDR_WIDTH(5), .DEPTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Count(Count),
    .InData(InData), .InValid(InValid), .InReady(InReady),
    .MemAddr(MemAddr), .MemData(MemData), .MemWrEn(MemWrEn),
    .ProcReset(ProcReset), .Busy(Busy), .Done(Done), .Error(Error)
  );

  // ---------------- clock ----------------
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [24:0] exp_q[$];   // {addr, data} of each accepted word, in order
  logic [19:0] shadow[32]; // memory image rebuilt from observed writes

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_LAST = 2, M_RUN = 3, M_ERR = 4;
  int          m_mode = M_IDLE;
  int          m_left = 0;
  int          m_next = 0;
  logic        m_wr   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [19:0] m_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic [5:0] c,
                            input logic v, input logic [19:0] d);
    int cnt;
    cnt = int'(c);
    if (r) begin
      m_mode = M_IDLE; m_wr = 1'b0; m_addr = '0; m_data = '0;
      m_next = 0; m_left = 0;
      exp_q.delete();
    end else begin
      m_wr = 1'b0;
      case (m_mode)
        M_IDLE, M_RUN: begin
          if (s) begin
            if (cnt > 32)       m_mode = M_ERR;
            else if (cnt == 0)  m_mode = M_RUN;
            else begin
              m_mode = M_LOAD; m_left = cnt; m_next = 0;
            end
          end
        end
        M_LOAD: begin
          if (v) begin
            m_wr   = 1'b1;
            m_addr = m_next[4:0];
            m_data = d;
            exp_q.push_back({m_next[4:0], d});
            m_next++;
            m_left--;
            if (m_left == 0) m_mode = M_LAST;
          end
        end
        M_LAST:  m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [24:0] e;
    check("in_ready",   InReady,   m_mode == M_LOAD);
    check("busy",       Busy,      (m_mode == M_LOAD) || (m_mode == M_LAST));
    check("done",       Done,      m_mode == M_RUN);
    check("error",      Error,     m_mode == M_ERR);
    check("proc_reset", ProcReset, m_mode != M_RUN);
    check("mem_wr_en",  MemWrEn,   m_wr);
    check("mem_addr",   MemAddr,   m_addr);
    check("mem_data",   MemData,   m_data);
    if (MemWrEn === 1'b1) begin
      shadow[MemAddr] = MemData;
      check("wr_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", MemAddr, e[24:20]);
        check("wr_data", MemData, e[19:0]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic r, s, v;
    logic [5:0]  c;
    logic [19:0] d;
    r = Reset; s = Start; c = Count; v = InValid; d = InData;
    @(posedge Clock);
    #1;
    model_step(r, s, c, v, d);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1; Start = 1'b0; InValid = 1'b0;
    repeat (n) tick();
    Reset = 1'b0;
  endtask

  task automatic start_load(input int c);
    Start   = 1'b1;
    Count   = c[5:0];
    InValid = 1'($urandom_range(0, 1));
    InData  = 20'($urandom);
    tick();
    Start   = 1'b0;
    Count   = 6'($urandom_range(0, 63));
    InValid = 1'b0;
  endtask

  task automatic send_word(input logic [19:0] d, input int gap, input bit poke_start);
    repeat (gap) begin
      InValid = 1'b0;
      InData  = 20'($urandom);
      tick();
    end
    InValid = 1'b1;
    InData  = d;
    if (poke_start) begin
      Start = 1'b1;
      Count = 6'($urandom_range(0, 40));
    end
    tick();
    InValid = 1'b0;
    Start   = 1'b0;
  endtask

  task automatic idle(input int n);
    InValid = 1'b0;
    repeat (n) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    Reset = 1'b0; Start = 1'b0; Count = '0; InData = '0; InValid = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // Reset state
    do_reset(2);
    idle(1);

    // Three words back-to-back
    start_load(3);
    send_word(20'h00011, 0, 1'b0);
    send_word(20'h00022, 0, 1'b0);
    send_word(20'h00033, 0, 1'b0);
    idle(2);

    // Two words with a 3-cycle gap, restarted from RUN
    start_load(2);
    send_word(20'hABCDE, 0, 1'b0);
    send_word(20'h12345, 3, 1'b0);
    idle(2);

    // Empty load, then an illegal count that only Reset clears
    start_load(0);
    idle(2);
    do_reset(1);
    start_load(33);
    idle(2);
    start_load(5);
    send_word(20'h0BEEF, 0, 1'b0);
    idle(2);
    do_reset(1);

    // Reset arriving on the third transfer cycle
    start_load(5);
    send_word(20'h11111, 0, 1'b0);
    send_word(20'h22222, 0, 1'b0);
    Reset = 1'b1; InValid = 1'b1; InData = 20'h33333;
    tick();
    Reset = 1'b0;
    repeat (4) begin
      InValid = 1'b1;
      InData  = 20'($urandom);
      tick();
    end
    idle(1);

    // Full-depth load from RUN, data = addr + 0x100
    start_load(0);
    idle(1);
    start_load(32);
    for (int a = 0; a < 32; a++) send_word(20'(a + 'h100), $urandom_range(0, 2), 1'b0);
    idle(3);
    for (int a = 0; a < 32; a++) check("full_image", shadow[a], 32'(a + 'h100));

    // Randomized sessions
    repeat (14) begin
      c = $urandom_range(0, 34);
      start_load(c);
      for (int w = 0; w < ((c >= 1 && c <= 32) ? c : 2); w++) begin
        if ($urandom_range(0, 19) == 0) do_reset(1);
        send_word(20'($urandom), $urandom_range(0, 2), $urandom_range(0, 7) == 0);
      end
      idle(2);
      if (c > 32 || $urandom_range(0, 4) == 0) do_reset(1);
    end

    idle(2);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the processor/memory pair.
- Accepts a stream of 20-bit program words over a valid/ready handshake and writes them into the main memory's write port at consecutive addresses starting at 0.
- Holds the pipeline processor in reset until the load completes, then releases it.
- Supports reload on request and flags an illegal word count.

Parameters:
- DATA_WIDTH, 20, memory word width
- ADDR_WIDTH, 5, memory address width
- DEPTH, 32, number of memory words; must be ≤ 2^ADDR_WIDTH

Ports:
- Clock  input  1  system clock; all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  load request; sampled in IDLE and RUN only
- Count  input  ADDR_WIDTH+1  number of words to load (0..DEPTH); sampled with Start
- InData  input  DATA_WIDTH  program word
- InValid  input  1  InData valid
- InReady  output  1  loader accepts a word this cycle
- MemAddr  output  ADDR_WIDTH  memory write address
- MemData  output  DATA_WIDTH  memory write data
- MemWrEn  output  1  memory write strobe, one cycle per word
- ProcReset  output  1  reset to processor; high except in RUN
- Busy  output  1  high in LOAD and DRAIN
- Done  output  1  level, high in RUN
- Error  output  1  level, high in ERROR

Behaviour:
- Reset is synchronous and active-high; it overrides all other inputs. After the Reset cycle:
  - state IDLE, internal pointer 0
  - MemWrEn 0, MemAddr 0, MemData 0, InReady 0
  - ProcReset 1, Busy 0, Done 0, Error 0
- All outputs are registered or decoded from the registered state only; no combinational path from any input to any output.
- States:
  - IDLE:
    - Start=0 → stay.
    - Start=1 and Count>DEPTH → ERROR.
    - Start=1 and Count=0 → RUN.
    - Otherwise → LOAD; latch Count; pointer=0.
  - LOAD:
    - InReady=1.
    - Transfer occurs when InValid=1 and InReady=1.
    - On a transfer in cycle t, in cycle t+1: MemWrEn=1, MemAddr=pointer, MemData=InData sampled at t. Pointer then increments.
    - Cycles without a transfer give MemWrEn=0 in the next cycle, with MemAddr/MemData holding their last values.
    - A transfer when pointer = latched Count−1 is the last one → DRAIN.
    - Start is ignored in LOAD.
  - DRAIN:
    - Lasts one cycle; InReady=0.
    - MemWrEn=1 for the last word in this cycle.
    - → RUN.
  - RUN:
    - ProcReset=0, Done=1, MemWrEn=0.
    - Start=1 with a legal Count restarts exactly as from IDLE: next cycle ProcReset=1, Done=0, state LOAD (or ERROR, or back to RUN for Count=0).
  - ERROR:
    - Error=1, ProcReset=1, InReady=0.
    - Start is ignored; only Reset exits.
- ProcReset deasserts in the cycle after the final MemWrEn pulse, so the processor never fetches a word that is not yet written.
- Back-to-back transfers give one write per cycle at consecutive addresses. Throughput is 1 word/cycle.
- Pointer never wraps. With Count=DEPTH=32 the last write is at address 31, and writes never exceed Count.
- InValid outside LOAD is ignored (InReady=0); data is not buffered.
- Reset mid-load:
  - Returns to IDLE the next cycle and any pending write strobe is cancelled.
  - Words already written remain in memory.
  - ProcReset stays 1 throughout.
- Count is latched at Start; later changes to Count are ignored until the next Start.

Test Plan:
- Reset for 2 cycles, all inputs 0 → ProcReset=1, MemWrEn=0, InReady=0, Busy=0, Done=0, Error=0, MemAddr=0.
- Start with Count=3, then stream 0x00011, 0x00022, 0x00033 back-to-back with InValid=1 → MemWrEn high for 3 consecutive cycles with (addr, data) = (0, 0x00011), (1, 0x00022), (2, 0x00033). The third write coincides with DRAIN. The next cycle gives ProcReset=0, Done=1, Busy=0.
- Start with Count=2, first word 0xABCDE, InValid low for 3 cycles, then second word 0x12345 → no MemWrEn during the gap; writes are (0, 0xABCDE) then (1, 0x12345); RUN follows.
- Start with Count=0 → no writes, RUN next cycle. Then Reset, Start with Count=33 → Error=1, ProcReset=1, InReady=0; further Start is ignored until Reset.
- Start with Count=5, transfer 2 words, assert Reset on the 3rd transfer cycle → no write at addr 2; state IDLE, Busy=0, ProcReset=1; subsequent InValid produces no writes.
- From RUN, Start with Count=32 and stream words 0..31 with data = addr+0x100 → ProcReset rises the next cycle; 32 writes go to addresses 0..31 with no wrap; ProcReset=0 one cycle after the write to address 31.
